if_fetch: RTL and testbench

Instruction-fetch responder that sits between the PC register and byte-wide instruction memory. It takes the current 16-bit PC address and reads two bytes from synchronous memory, low byte first. It assembles them into a 16-bit instruction and presents it to decode through a valid/ready handshake. It drives pc_en back to the PC register: once when decode accepts an instruction, and once on a branch redirect.

---
 rtl/if_fetch.sv | 116 +++++++++++
 tb/tb_if_fetch.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch responder: reads two bytes (low first) at pc_addr from
// synchronous byte memory, presents the 16-bit instruction via valid/ready.
module if_fetch #(
  parameter int unsigned ADDR_W    = 16,
  parameter logic [15:0] ERR_INSTR = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              redirect,
  output logic              pc_en,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [15:0]       instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              fetch_err
);

  typedef enum logic [2:0] {IDLE, LO, HI, CAP, VALID} state_e;

  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [7:0]  lo_q, lo_d;
  logic        accept;

  assign accept = (state_q == VALID) && valid_q && instr_ready && !redirect;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = LO;
      LO:      state_d = pc_addr[0] ? VALID : HI;
      HI:      state_d = CAP;
      CAP:     state_d = VALID;
      VALID:   if (accept) state_d = LO;
      default: state_d = IDLE;
    endcase
    // Redirect from any state restarts the fetch at the newly loaded PC.
    if (redirect) state_d = LO;
  end

  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = pc_addr;
    pc_en    = 1'b0;
    unique case (state_q)
      LO:      mem_rd = ~pc_addr[0];
      HI: begin
        mem_rd   = 1'b1;
        mem_addr = pc_addr + ADDR_W'(1);
      end
      VALID:   pc_en = accept;
      default: ;
    endcase
    if (redirect) pc_en = 1'b1;
    if (!rst) begin
      mem_rd = 1'b0;
      pc_en  = 1'b0;
    end
  end

  always_comb begin
    instr_d = instr_q;
    valid_d = valid_q;
    err_d   = err_q;
    lo_d    = lo_q;
    if (state_q == HI) lo_d = mem_rdata;
    if (redirect) begin
      valid_d = 1'b0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        LO: if (pc_addr[0]) begin
          instr_d = ERR_INSTR;
          err_d   = 1'b1;
          valid_d = 1'b1;
        end
        CAP: begin
          instr_d = {mem_rdata, lo_q};
          err_d   = 1'b0;
          valid_d = 1'b1;
        end
        VALID:   if (accept) valid_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      instr_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      lo_q    <= '0;
    end else begin
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      lo_q    <= lo_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: byte memory model plus hand-sequenced PC values.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_addr;
  logic        redirect;
  logic        pc_en;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        fetch_err;

  logic [7:0] mem [256];
  int errors = 0;
  int checks = 0;

  if_fetch #(.ADDR_W(16), .ERR_INSTR(16'h0000)) dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .redirect(redirect),
    .pc_en(pc_en), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data one cycle after the strobe, filler otherwise.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr[7:0]];
    else        mem_rdata <= 8'h5A;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'hA5);
    mem[8'h00] = 8'h34; mem[8'h01] = 8'h12;
    mem[8'h02] = 8'hEF; mem[8'h03] = 8'hBE;
    mem[8'h40] = 8'hCD; mem[8'h41] = 8'hAB;
    mem[8'h14] = 8'h22; mem[8'h15] = 8'h11;

    rst = 1'b0; redirect = 1'b0; instr_ready = 1'b1; pc_addr = 16'h0000;

    // Test 1: reset, bubble, basic fetch
    cyc(); settle();
    chk("rst_mem_rd", 32'(mem_rd), 0);
    chk("rst_pc_en", 32'(pc_en), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_err", 32'(fetch_err), 0);
    cyc(); rst = 1'b1; settle();
    chk("idle_mem_rd", 32'(mem_rd), 0);
    chk("idle_pc_en", 32'(pc_en), 0);
    cyc(); settle();
    chk("t1_lo_rd", 32'(mem_rd), 1);
    chk("t1_lo_addr", 32'(mem_addr), 32'h0000);
    cyc(); settle();
    chk("t1_hi_rd", 32'(mem_rd), 1);
    chk("t1_hi_addr", 32'(mem_addr), 32'h0001);
    cyc(); settle();
    chk("t1_cap_rd", 32'(mem_rd), 0);
    chk("t1_cap_valid", 32'(instr_valid), 0);
    cyc(); settle();
    chk("t1_valid", 32'(instr_valid), 1);
    chk("t1_instr", 32'(instr), 32'h1234);
    chk("t1_err", 32'(fetch_err), 0);
    chk("t1_pc_en", 32'(pc_en), 1);
    cyc(); pc_addr = 16'h0002; instr_ready = 1'b0; settle();
    chk("t1_next_rd", 32'(mem_rd), 1);
    chk("t1_next_addr", 32'(mem_addr), 32'h0002);
    chk("t1_next_pc_en", 32'(pc_en), 0);
    chk("t1_next_valid", 32'(instr_valid), 0);

    // Test 2: backpressure on 0xBEEF
    cyc(); cyc(); cyc(); settle();
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", 32'(instr_valid), 1);
      chk("t2_hold_instr", 32'(instr), 32'hBEEF);
      chk("t2_hold_pc_en", 32'(pc_en), 0);
      chk("t2_hold_rd", 32'(mem_rd), 0);
      cyc(); settle();
    end
    instr_ready = 1'b1; settle();
    chk("t2_acc_pc_en", 32'(pc_en), 1);
    chk("t2_acc_valid", 32'(instr_valid), 1);
    cyc(); pc_addr = 16'h0004; settle();
    chk("t2_after_valid", 32'(instr_valid), 0);
    chk("t2_after_pc_en", 32'(pc_en), 0);
    chk("t2_after_addr", 32'(mem_addr), 32'h0004);

    // Test 3: redirect during HI
    cyc(); redirect = 1'b1; settle();
    chk("t3_hi_addr", 32'(mem_addr), 32'h0005);
    chk("t3_redir_pc_en", 32'(pc_en), 1);
    cyc(); redirect = 1'b0; pc_addr = 16'h0040; settle();
    chk("t3_lo_rd", 32'(mem_rd), 1);
    chk("t3_lo_addr", 32'(mem_addr), 32'h0040);
    chk("t3_lo_pc_en", 32'(pc_en), 0);
    chk("t3_lo_valid", 32'(instr_valid), 0);
    cyc(); cyc(); settle();
    chk("t3_cap_valid", 32'(instr_valid), 0);
    cyc(); settle();
    chk("t3_instr", 32'(instr), 32'hABCD);
    chk("t3_pc_en", 32'(pc_en), 1);

    // Test 4: misaligned PC
    cyc(); pc_addr = 16'h0013; settle();
    chk("t4_lo_rd", 32'(mem_rd), 0);
    chk("t4_lo_pc_en", 32'(pc_en), 0);
    cyc(); settle();
    chk("t4_valid", 32'(instr_valid), 1);
    chk("t4_instr", 32'(instr), 32'h0000);
    chk("t4_err", 32'(fetch_err), 1);
    chk("t4_pc_en", 32'(pc_en), 1);

    // Test 5: reset during CAP
    cyc(); pc_addr = 16'h0014; settle();
    chk("t5_lo_addr", 32'(mem_addr), 32'h0014);
    chk("t5_lo_valid", 32'(instr_valid), 0);
    cyc(); cyc(); rst = 1'b0; settle();
    chk("t5_rst_rd", 32'(mem_rd), 0);
    chk("t5_rst_pc_en", 32'(pc_en), 0);
    cyc(); rst = 1'b1; settle();
    chk("t5_idle_valid", 32'(instr_valid), 0);
    chk("t5_idle_instr", 32'(instr), 0);
    chk("t5_idle_err", 32'(fetch_err), 0);
    chk("t5_idle_rd", 32'(mem_rd), 0);
    chk("t5_idle_pc_en", 32'(pc_en), 0);
    cyc(); settle();
    chk("t5_lo_rd2", 32'(mem_rd), 1);
    chk("t5_lo_addr2", 32'(mem_addr), 32'h0014);
    cyc(); cyc(); cyc(); settle();
    chk("t5_instr", 32'(instr), 32'h1122);

    // Test 6: redirect and ready together in VALID
    redirect = 1'b1; settle();
    chk("t6_pc_en", 32'(pc_en), 1);
    chk("t6_valid", 32'(instr_valid), 1);
    cyc(); redirect = 1'b0; pc_addr = 16'h0040; settle();
    chk("t6_after_valid", 32'(instr_valid), 0);
    chk("t6_after_pc_en", 32'(pc_en), 0);
    chk("t6_after_rd", 32'(mem_rd), 1);
    chk("t6_after_addr", 32'(mem_addr), 32'h0040);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
